// File: rtl/output_drain_if.sv
// Handshake bundle between output_drain and its neighbours: output_fifo pop side,
// host result port, input_fifo recirculation side, and status counters.
interface output_drain_if #(
  parameter int VAL_W = 16,
  parameter int LT_W  = 16,
  parameter int CNT_W = 16
);
  logic                    of_empty;
  logic [VAL_W+LT_W-1:0]   of_data;
  logic                    of_de;
  logic                    host_valid;
  logic [VAL_W-1:0]        host_data;
  logic [LT_W-1:0]         host_lt;
  logic                    host_ready;
  logic                    if_full;
  logic                    if_en;
  logic [VAL_W+LT_W-1:0]   if_data;
  logic [CNT_W-1:0]        out_cnt;
  logic [CNT_W-1:0]        drop_cnt;
  logic                    busy;

  modport master (
    input  of_empty, of_data, host_ready, if_full,
    output of_de, host_valid, host_data, host_lt, if_en, if_data, out_cnt, drop_cnt, busy
  );

  modport slave (
    output of_empty, of_data, host_ready, if_full,
    input  of_de, host_valid, host_data, host_lt, if_en, if_data, out_cnt, drop_cnt, busy
  );
endinterface

// File: rtl/output_drain.sv
// Drains output_fifo tokens to the host with optional ReLU and recirculates tokens that
// still have lifetime left back into input_fifo; counts emitted and dropped tokens.
module output_drain #(
  parameter int VAL_W     = 16,
  parameter int LT_W      = 16,
  parameter int ACT_MODE  = 1,
  parameter int RECIRC_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output_drain_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    RECIRC = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [VAL_W-1:0]   r_val;
  logic [VAL_W-1:0]   r_act;
  logic [LT_W-1:0]    r_lt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic               w_pop;
  logic               w_push;
  logic               w_accept;
  logic [VAL_W-1:0]   w_in_val;
  logic [LT_W-1:0]    w_in_lt;
  logic [VAL_W-1:0]   w_in_act;
  logic               w_lt_gt1;

  assign w_in_val = bus.of_data[VAL_W+LT_W-1:LT_W];
  assign w_in_lt  = bus.of_data[LT_W-1:0];
  // Activation is computed once at pop time so host_data is a plain register output.
  assign w_in_act = (ACT_MODE != 0 && w_in_val[VAL_W-1]) ? '0 : w_in_val;
  assign w_lt_gt1 = (r_lt > LT_W'(1));

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_push   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !bus.of_empty;
        if (w_pop && (w_in_lt != '0)) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.host_ready) begin
          w_accept = 1'b1;
          w_next   = (RECIRC_EN != 0 && w_lt_gt1) ? RECIRC : IDLE;
        end
      end
      RECIRC: begin
        w_push = !bus.if_full;
        if (w_push) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Strobes are masked while reset is held so neither FIFO is touched during reset.
  assign bus.of_de = reset && w_pop;
  assign bus.if_en = reset && w_push;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_val      <= '0;
      r_act      <= '0;
      r_lt       <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_val <= w_in_val;
        r_act <= w_in_act;
        r_lt  <= w_in_lt;
        if (w_in_lt == '0) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
      if (w_accept) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.host_valid = (r_state == EMIT);
  assign bus.host_data  = r_act;
  assign bus.host_lt    = r_lt;
  assign bus.if_data    = {r_val, r_lt - LT_W'(1)};
  assign bus.out_cnt    = r_out_cnt;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_output_drain.sv
// Self-checking bench for output_drain: vector table, hand-built corner sequences,
// randomized scoreboard run, and counter wrap on a narrow-counter identity instance.
module tb_output_drain;

  logic clk;
  logic reset;
  logic reset2;

  output_drain_if #(.VAL_W(16), .LT_W(16), .CNT_W(16)) bus ();
  output_drain_if #(.VAL_W(16), .LT_W(16), .CNT_W(4))  bus2 ();

  output_drain #(.VAL_W(16), .LT_W(16), .ACT_MODE(1), .RECIRC_EN(1), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  output_drain #(.VAL_W(16), .LT_W(16), .ACT_MODE(0), .RECIRC_EN(0), .CNT_W(4)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] token;
    bit          emit;
    logic [15:0] hostData;
    bit          recirc;
    logic [31:0] ifData;
  } vec_t;

  int total = 0;
  int bad = 0;
  int expOut = 0;
  int expDrop = 0;

  logic [31:0] ofQ[$];
  logic [31:0] hostQ[$];
  logic [31:0] recQ[$];

  logic        sDe, sEn, sHv, sRdy, sBusy;
  logic [15:0] sHd, sHl, sOut, sDrop;
  logic [31:0] sId;
  logic        pHv = 1'b0;
  logic        pRdy = 1'b0;
  logic [15:0] pHd = '0;
  logic [15:0] pHl = '0;
  logic        s2Hv, s2En;
  logic [15:0] s2Hd, s2Hl;
  logic [3:0]  s2Out, s2Drop;

  bit rndOn = 1'b0;
  bit s2On = 1'b0;
  bit s2DropPhase = 1'b0;
  int hs2Count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: unexpected event", name);
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
    return ($signed(v) < 0) ? 16'h0000 : v;
  endfunction

  task automatic refresh();
    bus.of_empty = (ofQ.size() == 0);
    bus.of_data  = (ofQ.size() == 0) ? 32'h0 : ofQ[0];
  endtask

  // Snapshot outputs at the falling edge, then let the rising edge happen and
  // retire the head of the source FIFO model if the DUT popped it.
  task automatic tick();
    logic [31:0] tmp;
    @(negedge clk);
    sDe = bus.of_de; sEn = bus.if_en; sHv = bus.host_valid; sRdy = bus.host_ready;
    sHd = bus.host_data; sHl = bus.host_lt; sId = bus.if_data; sBusy = bus.busy;
    sOut = bus.out_cnt; sDrop = bus.drop_cnt;
    s2Hv = bus2.host_valid; s2En = bus2.if_en; s2Hd = bus2.host_data; s2Hl = bus2.host_lt;
    s2Out = bus2.out_cnt; s2Drop = bus2.drop_cnt;
    checkOutput("exclusive_valid_en", {31'b0, sHv & sEn}, 32'h0);
    if (rndOn) begin
      if (pHv && !pRdy) begin
        checkOutput("rnd_hold_valid", {31'b0, sHv}, 32'h1);
        checkOutput("rnd_hold_data", {sHd, sHl}, {pHd, pHl});
      end
      if (sHv && sRdy) begin
        if (hostQ.size() == 0) reportFail("rnd_host_extra");
        else begin
          tmp = hostQ.pop_front();
          checkOutput("rnd_host", {sHd, sHl}, tmp);
        end
      end
      if (sEn) begin
        if (recQ.size() == 0) reportFail("rnd_recirc_extra");
        else begin
          tmp = recQ.pop_front();
          checkOutput("rnd_recirc", sId, tmp);
        end
      end
      pHv = sHv; pRdy = sRdy; pHd = sHd; pHl = sHl;
    end
    if (s2On) begin
      checkOutput("id_no_recirc", {31'b0, s2En}, 32'h0);
      if (s2Hv) begin
        if (s2DropPhase) reportFail("id_valid_on_drop");
        else begin
          hs2Count++;
          checkOutput("id_data", {s2Hd, s2Hl}, 32'h80010005);
        end
      end
    end
    @(posedge clk);
    #1;
    if (sDe) begin
      if (ofQ.size() == 0) reportFail("pop_when_empty");
      else tmp = ofQ.pop_front();
    end
    refresh();
  endtask

  // One token end to end with host_ready=1 and if_full=0, starting from an idle DUT.
  task automatic applyStimulus(input vec_t v);
    ofQ.push_back(v.token);
    refresh();
    bus.host_ready = 1'b1;
    bus.if_full = 1'b0;
    tick();
    checkOutput("vec_pop", {31'b0, sDe}, 32'h1);
    checkOutput("vec_pop_busy", {31'b0, sBusy}, 32'h0);
    if (v.emit) begin
      tick();
      expOut++;
      checkOutput("vec_host_valid", {31'b0, sHv}, 32'h1);
      checkOutput("vec_host_data", {16'h0, sHd}, {16'h0, v.hostData});
      checkOutput("vec_host_lt", {16'h0, sHl}, {16'h0, v.token[15:0]});
      checkOutput("vec_no_pop_emit", {31'b0, sDe}, 32'h0);
      if (v.recirc) begin
        tick();
        checkOutput("vec_if_en", {31'b0, sEn}, 32'h1);
        checkOutput("vec_if_data", sId, v.ifData);
        checkOutput("vec_busy_recirc", {31'b0, sBusy}, 32'h1);
      end
    end else begin
      expDrop++;
    end
    tick();
    checkOutput("vec_idle_busy", {31'b0, sBusy}, 32'h0);
    checkOutput("vec_idle_valid", {31'b0, sHv}, 32'h0);
    checkOutput("vec_idle_if_en", {31'b0, sEn}, 32'h0);
    checkOutput("vec_out_cnt", {16'h0, sOut}, expOut);
    checkOutput("vec_drop_cnt", {16'h0, sDrop}, expDrop);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int nEmit;
    int nDrop;
    bit done;
    logic [15:0] v;
    logic [15:0] lt;
    int r;

    vecs[0] = '{32'hfffe0001, 1'b1, 16'h0000, 1'b0, 32'h0};
    vecs[1] = '{32'h00050003, 1'b1, 16'h0005, 1'b1, 32'h00050002};
    vecs[2] = '{32'h00070000, 1'b0, 16'h0000, 1'b0, 32'h0};
    vecs[3] = '{32'h7fffffff, 1'b1, 16'h7fff, 1'b1, 32'h7ffffffe};
    vecs[4] = '{32'h8000ffff, 1'b1, 16'h0000, 1'b1, 32'h8000fffe};
    vecs[5] = '{32'h12340002, 1'b1, 16'h1234, 1'b1, 32'h12340001};
    vecs[6] = '{32'h0001_0001, 1'b1, 16'h0001, 1'b0, 32'h0};
    vecs[7] = '{32'hffff0000, 1'b0, 16'h0000, 1'b0, 32'h0};

    reset = 1'b0;
    reset2 = 1'b0;
    bus.host_ready = 1'b0;
    bus.if_full = 1'b0;
    bus2.of_empty = 1'b1;
    bus2.of_data = 32'h0;
    bus2.host_ready = 1'b1;
    bus2.if_full = 1'b0;
    refresh();

    // Reset state, and no pop while reset is held even with data available.
    tick();
    ofQ.push_back(32'h00090001);
    refresh();
    tick();
    checkOutput("reset_no_pop", {31'b0, sDe}, 32'h0);
    checkOutput("reset_valid", {31'b0, sHv}, 32'h0);
    checkOutput("reset_busy", {31'b0, sBusy}, 32'h0);
    checkOutput("reset_if_en", {31'b0, sEn}, 32'h0);
    checkOutput("reset_out_cnt", {16'h0, sOut}, 32'h0);
    checkOutput("reset_drop_cnt", {16'h0, sDrop}, 32'h0);
    ofQ.delete();
    refresh();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Host back-pressure with a second token queued behind the pending result.
    ofQ.push_back(32'h00110001);
    ofQ.push_back(32'h00220001);
    refresh();
    bus.host_ready = 1'b0;
    tick();
    checkOutput("bp_pop", {31'b0, sDe}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid", {31'b0, sHv}, 32'h1);
      checkOutput("bp_data", {sHd, sHl}, 32'h00110001);
      checkOutput("bp_no_pop", {31'b0, sDe}, 32'h0);
    end
    bus.host_ready = 1'b1;
    tick();
    checkOutput("bp_accept", {sHd, sHl}, 32'h00110001);
    tick();
    checkOutput("bp_next_pop", {31'b0, sDe}, 32'h1);
    checkOutput("bp_next_idle", {31'b0, sHv}, 32'h0);
    tick();
    checkOutput("bp_second", {sHd, sHl}, 32'h00220001);
    tick();
    expOut += 2;
    checkOutput("bp_out_cnt", {16'h0, sOut}, expOut);
    checkOutput("bp_idle", {31'b0, sBusy}, 32'h0);

    // input_fifo full while a negative token waits to recirculate.
    ofQ.push_back(32'hfffd0004);
    refresh();
    bus.if_full = 1'b1;
    tick();
    tick();
    checkOutput("full_relu", {sHd, sHl}, 32'h00000004);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("full_no_en", {31'b0, sEn}, 32'h0);
      checkOutput("full_busy", {31'b0, sBusy}, 32'h1);
      checkOutput("full_if_data", sId, 32'hfffd0003);
    end
    bus.if_full = 1'b0;
    tick();
    checkOutput("full_release_en", {31'b0, sEn}, 32'h1);
    checkOutput("full_release_data", sId, 32'hfffd0003);
    tick();
    checkOutput("full_idle", {31'b0, sBusy}, 32'h0);

    // Reset while a result is pending: token discarded, next one popped fresh.
    ofQ.push_back(32'h00330002);
    ofQ.push_back(32'h00440001);
    refresh();
    bus.host_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_pending", {31'b0, sHv}, 32'h1);
    reset = 1'b0;
    tick();
    checkOutput("rst_no_pop", {31'b0, sDe}, 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("rst_valid", {31'b0, sHv}, 32'h0);
    checkOutput("rst_busy", {31'b0, sBusy}, 32'h0);
    checkOutput("rst_out_cnt", {16'h0, sOut}, 32'h0);
    checkOutput("rst_drop_cnt", {16'h0, sDrop}, 32'h0);
    checkOutput("rst_pop_next", {31'b0, sDe}, 32'h1);
    tick();
    checkOutput("rst_next_token", {sHd, sHl}, 32'h00440001);
    bus.host_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_out_after", {16'h0, sOut}, 32'h1);
    checkOutput("rst_no_recirc", {31'b0, sEn}, 32'h0);

    // Randomized run against a transaction-level expectation.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    nEmit = 0;
    nDrop = 0;
    for (int i = 0; i < 80; i++) begin
      v = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) lt = 16'h0;
      else if (r < 5) lt = 16'h1;
      else if (r < 8) lt = 16'($urandom_range(2, 5));
      else if (r == 8) lt = 16'hffff;
      else lt = 16'($urandom_range(2, 65535));
      ofQ.push_back({v, lt});
      if (lt == 0) nDrop++;
      else begin
        nEmit++;
        hostQ.push_back({relu(v), lt});
        if (lt > 1) recQ.push_back({v, lt - 16'd1});
      end
    end
    refresh();
    pHv = 1'b0;
    rndOn = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      bus.host_ready = ($urandom_range(0, 3) != 0);
      bus.if_full = ($urandom_range(0, 2) == 0);
      tick();
      done = (ofQ.size() == 0) && (hostQ.size() == 0) && (recQ.size() == 0) && !sBusy;
    end
    rndOn = 1'b0;
    checkOutput("rnd_complete", {31'b0, done}, 32'h1);
    bus.host_ready = 1'b1;
    bus.if_full = 1'b0;
    tick();
    checkOutput("rnd_out_cnt", {16'h0, sOut}, nEmit);
    checkOutput("rnd_drop_cnt", {16'h0, sDrop}, nDrop);

    // Narrow counters on the identity, no-recirc instance: wrap and raw negative passthrough.
    reset2 = 1'b1;
    bus2.of_data = 32'h80010005;
    bus2.of_empty = 1'b0;
    s2On = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
    end
    bus2.of_empty = 1'b1;
    tick();
    checkOutput("wrap_handshakes", hs2Count, 32'd35);
    checkOutput("wrap_out_cnt", {28'h0, s2Out}, 32'd3);
    s2DropPhase = 1'b1;
    bus2.of_data = 32'h12340000;
    bus2.of_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    bus2.of_empty = 1'b1;
    tick();
    checkOutput("wrap_drop_cnt", {28'h0, s2Drop}, 32'd4);
    checkOutput("wrap_out_hold", {28'h0, s2Out}, 32'd3);
    s2On = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
